// File: rtl/engine_rpm_model_if.sv
// Signal bundle between the engine RPM model and its driver/display consumers.
// The driver side supplies pedal inputs; the model side returns RPM, gear and LED bar state.
interface engine_rpm_model_if;
    logic        throttle;
    logic        brake;
    logic [12:0] rpm;
    logic [2:0]  gear;
    logic        shifting;
    logic [31:0] rpm_bar;

    modport master (
        output throttle,
        output brake,
        input  rpm,
        input  gear,
        input  shifting,
        input  rpm_bar
    );

    modport slave (
        input  throttle,
        input  brake,
        output rpm,
        output gear,
        output shifting,
        output rpm_bar
    );
endinterface

// File: rtl/engine_rpm_model.sv
// Tick-based engine RPM and 4-speed gearbox model with saturating RPM and an LED bar readout.
// Pedals are sampled once per prescaler tick; an upshift, once started, always runs to completion.
module engine_rpm_model #(
    parameter int TICK_DIV       = 50000,
    parameter int RPM_IDLE       = 800,
    parameter int RPM_MAX        = 8191,
    parameter int UPSHIFT_RPM    = 6000,
    parameter int DOWNSHIFT_RPM  = 2000,
    parameter int ACCEL_STEP     = 200,
    parameter int DECEL_STEP     = 50,
    parameter int SHIFT_STEP     = 500,
    parameter int SHIFT_TICKS    = 4,
    parameter int DOWNSHIFT_BUMP = 1500
) (
    input  logic               clk,
    input  logic               rst_n,
    engine_rpm_model_if.slave  bus
);

    typedef enum logic [0:0] {
        DRIVE   = 1'b0,
        UPSHIFT = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int SC_W  = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [SC_W-1:0]  SHIFT_LAST = SC_W'(SHIFT_TICKS - 1);

    // 15-bit arithmetic domain keeps every sum and threshold free of wrap
    localparam logic [14:0] IDLE_W  = 15'(RPM_IDLE);
    localparam logic [14:0] MAX_W   = 15'(RPM_MAX);
    localparam logic [14:0] UP_W    = 15'(UPSHIFT_RPM);
    localparam logic [14:0] DOWN_W  = 15'(DOWNSHIFT_RPM);
    localparam logic [14:0] ACCEL_W = 15'(ACCEL_STEP);
    localparam logic [14:0] DECEL_W = 15'(DECEL_STEP);
    localparam logic [14:0] BRAKE_W = 15'(4 * DECEL_STEP);
    localparam logic [14:0] SHIFT_W = 15'(SHIFT_STEP);
    localparam logic [14:0] BUMP_W  = 15'(DOWNSHIFT_BUMP);

    localparam logic [12:0] IDLE_RPM = 13'(RPM_IDLE);
    localparam logic [12:0] MAX_RPM  = 13'(RPM_MAX);

    function automatic logic [12:0] sat_add(input logic [12:0] r, input logic [14:0] step);
        logic [14:0] sum;
        sum = {2'b00, r} + step;
        if (sum > MAX_W) begin
            return MAX_RPM;
        end else begin
            return sum[12:0];
        end
    endfunction

    function automatic logic [12:0] sat_sub(input logic [12:0] r, input logic [14:0] step);
        logic [14:0] diff;
        diff = {2'b00, r} - step;
        if ({2'b00, r} >= (IDLE_W + step)) begin
            return diff[12:0];
        end else begin
            return IDLE_RPM;
        end
    endfunction

    // Thermometer of the top five RPM bits, bit 31 flags redline
    function automatic logic [31:0] bar_pattern(input logic [12:0] r);
        logic [31:0] b;
        b = 32'd0;
        for (int i = 0; i < 31; i++) begin
            b[i] = (5'(i) < r[12:8]);
        end
        b[31] = (r == MAX_RPM);
        return b;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    state_t           state_r;
    state_t           state_s;
    logic [12:0]      rpm_r;
    logic [12:0]      rpm_s;
    logic [2:0]       gear_r;
    logic [2:0]       gear_s;
    logic [SC_W-1:0]  sc_r;
    logic [SC_W-1:0]  sc_s;
    logic             shifting_r;
    logic [31:0]      bar_r;

    assign tick_s = (cnt_r == CNT_LAST);

    // Prescaler producing one tick every TICK_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Next-state and next-RPM/gear decision, applied only on tick cycles
    always_comb begin
        state_s = state_r;
        rpm_s   = rpm_r;
        gear_s  = gear_r;
        sc_s    = sc_r;
        case (state_r)
            DRIVE: begin
                if ((gear_r > 3'd1) && ({2'b00, rpm_r} <= DOWN_W) &&
                    (!bus.throttle || bus.brake)) begin
                    gear_s = gear_r - 3'd1;
                    rpm_s  = sat_add(rpm_r, BUMP_W);
                end else if ((gear_r < 3'd4) && ({2'b00, rpm_r} >= UP_W) &&
                             bus.throttle && !bus.brake) begin
                    state_s = UPSHIFT;
                    sc_s    = '0;
                end else if (bus.brake) begin
                    rpm_s = sat_sub(rpm_r, BRAKE_W);
                end else if (bus.throttle) begin
                    // Higher gears gain RPM more slowly
                    rpm_s = sat_add(rpm_r, ACCEL_W >> (gear_r - 3'd1));
                end else begin
                    rpm_s = sat_sub(rpm_r, DECEL_W);
                end
            end
            UPSHIFT: begin
                rpm_s = sat_sub(rpm_r, SHIFT_W);
                if (sc_r == SHIFT_LAST) begin
                    gear_s  = gear_r + 3'd1;
                    state_s = DRIVE;
                    sc_s    = '0;
                end else begin
                    sc_s = sc_r + SC_W'(1);
                end
            end
            default: begin
                state_s = DRIVE;
                sc_s    = '0;
            end
        endcase
    end

    // Model state register, advanced on tick cycles only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= DRIVE;
            rpm_r      <= IDLE_RPM;
            gear_r     <= 3'd1;
            sc_r       <= '0;
            shifting_r <= 1'b0;
        end else if (tick_s) begin
            state_r    <= state_s;
            rpm_r      <= rpm_s;
            gear_r     <= gear_s;
            sc_r       <= sc_s;
            shifting_r <= (state_s == UPSHIFT);
        end else begin
            state_r    <= state_r;
            rpm_r      <= rpm_r;
            gear_r     <= gear_r;
            sc_r       <= sc_r;
            shifting_r <= shifting_r;
        end
    end

    // LED bar follows the registered RPM one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bar_r <= bar_pattern(IDLE_RPM);
        end else begin
            bar_r <= bar_pattern(rpm_r);
        end
    end

    assign bus.rpm      = rpm_r;
    assign bus.gear     = gear_r;
    assign bus.shifting = shifting_r;
    assign bus.rpm_bar  = bar_r;

endmodule

// File: doc/engine_rpm_model.md
ENGINE_RPM_MODEL -- requirements
Module: engine_rpm_model

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per model tick (>=2).
REQ-002 Parameter RPM_IDLE, default 800, RPM floor and reset value.
REQ-003 Parameter RPM_MAX, default 8191, RPM ceiling (redline).
REQ-004 Parameter UPSHIFT_RPM, default 6000; DOWNSHIFT_RPM, default 2000.
REQ-005 Parameter ACCEL_STEP, default 200; DECEL_STEP, default 50; SHIFT_STEP, default 500; SHIFT_TICKS, default 4; DOWNSHIFT_BUMP, default 1500.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 throttle  input  1  accelerator pressed, sampled on tick cycles only.
REQ-009 brake  input  1  brake pressed, sampled on tick cycles only.
REQ-010 rpm  output  13  current engine RPM, unsigned, registered.
REQ-011 gear  output  3  current gear 1..4, registered.
REQ-012 shifting  output  1  high while upshift in progress, registered.
REQ-013 rpm_bar  output  32  LED bar pattern consumed by the RPM display stage, registered.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the count equals TICK_DIV-1.
REQ-015 rpm, gear, shifting and FSM state change only on tick cycles; they hold between ticks.
REQ-016 FSM states: DRIVE, UPSHIFT; no other states are reachable.
REQ-017 DRIVE, tick, priority 1: gear>1, rpm<=DOWNSHIFT_RPM, and (!throttle or brake) -> gear-1, rpm=min(rpm+DOWNSHIFT_BUMP, RPM_MAX), stay DRIVE.
REQ-018 DRIVE, tick, priority 2: gear<4, rpm>=UPSHIFT_RPM, throttle and !brake -> enter UPSHIFT, rpm unchanged, shift counter=0.
REQ-019 DRIVE, tick, otherwise: brake -> rpm-=4*DECEL_STEP; throttle only -> rpm+=ACCEL_STEP>>(gear-1); neither -> rpm-=DECEL_STEP.
REQ-020 Brake and throttle both high: brake wins (decelerate, no upshift).
REQ-021 rpm saturates: never below RPM_IDLE, never above RPM_MAX; intermediate arithmetic is 14-bit or wider so no wrap occurs.
REQ-022 UPSHIFT, each tick: rpm=max(rpm-SHIFT_STEP, RPM_IDLE), counter+1; on the SHIFT_TICKS-th UPSHIFT tick gear+1 and return to DRIVE in the same update.
REQ-023 UPSHIFT ignores throttle and brake; a started shift always completes.
REQ-024 shifting=1 exactly while state is UPSHIFT.
REQ-025 gear 4 never upshifts; gear 1 never downshifts.
REQ-026 rpm_bar[i]=1 for i < rpm[12:8] (i=0..30), 0 otherwise; rpm_bar[31]=1 iff rpm==RPM_MAX.
REQ-027 rpm_bar is registered from rpm: it lags rpm by exactly one clk cycle.

Reset
REQ-028 rst_n=0 at a posedge: prescaler=0, rpm=RPM_IDLE, gear=1, state=DRIVE, shift counter=0, shifting=0, rpm_bar=pattern of RPM_IDLE (0x00000007 with defaults).
REQ-029 Reset overrides any in-progress upshift or tick; first tick after release occurs TICK_DIV cycles after the release edge.

Verification (TICK_DIV=4, other defaults)
REQ-030 Reset, inputs low -> rpm=800, gear=1, shifting=0, rpm_bar=0x00000007; after 10 ticks rpm still 800.
REQ-031 Throttle held from reset -> rpm=1000 after tick 1, 6000 after tick 26; UPSHIFT on tick 27 (shifting=1, rpm 6000); ticks 28-31 rpm 5500,5000,4500,4000; after tick 31 gear=2, shifting=0.
REQ-032 gear=2, rpm=2000, throttle=0 -> next tick gear=1, rpm=3500; rpm_bar=0x00001FFF one cycle later.
REQ-033 gear=4, throttle held until rpm saturates -> rpm=8191, +25/tick before clamp, rpm_bar=0xFFFFFFFF, no upshift.
REQ-034 throttle and brake both high at rpm=6000 gear 1 -> no UPSHIFT, rpm=5800 after tick; rst_n pulsed mid-UPSHIFT -> REQ-028 values next cycle.
